// File: rtl/pipe_int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_int_ctrl_pkg
// Shared pipeline-control definitions: interrupt sequencer states, PC source
// codes, injected micro-op codes and the default drain length.
// -----------------------------------------------------------------------------
package pipe_int_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DRAIN      = 3'd1,
    SAVE_PC    = 3'd2,
    SAVE_FLAGS = 3'd3,
    VECTOR     = 3'd4
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_VECTOR = 2'b10;

  localparam logic [1:0] INJ_NONE       = 2'b00;
  localparam logic [1:0] INJ_PUSH_PC    = 2'b01;
  localparam logic [1:0] INJ_PUSH_FLAGS = 2'b10;

  localparam int unsigned DRAIN_CYC_DEFAULT = 32'd3;

endpackage

// File: rtl/pipe_int_ctrl_edge.sv
// -----------------------------------------------------------------------------
// int_edge_latch
// Detects a rising edge of the interrupt request level and holds it as a
// pending flag until the sequencer takes the vector.
// Ports:
//   clk      in  clock
//   rst      in  asynchronous active-low reset
//   int_req  in  interrupt request level
//   clr      in  vector taken this cycle; clears pending
//   pending  out latched interrupt awaiting service
// -----------------------------------------------------------------------------
module int_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic int_req,
  input  logic clr,
  output logic pending
);

  logic int_req_prev_r;
  logic pending_r;
  logic rise_s;

  assign rise_s  = int_req & ~int_req_prev_r;
  assign pending = pending_r;

  // Previous request level and pending flag; a clear wins over a new edge,
  // and edges arriving while already pending are simply absorbed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_req_prev_r <= 1'b0;
      pending_r      <= 1'b0;
    end else begin
      int_req_prev_r <= int_req;
      if (clr) begin
        pending_r <= 1'b0;
      end else if (rise_s) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

endmodule

// File: rtl/pipe_int_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_int_ctrl
// Pipeline stall/flush control with an interrupt entry sequencer: drains the
// pipe, injects push-PC and push-flags micro-ops, then redirects to the vector.
// Outputs are combinational from state and inputs.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   int_req           interrupt request level
//   load_use_hazard   decode load-use hazard
//   branch_taken      execute redirect
//   mem_busy          memory stage stall
//   fd_enable/fd_flush, de_flush, pc_enable, pc_sel, inject_op
//   int_ack           one-cycle pulse when the vector is taken
//   int_pending       latched interrupt awaiting service
// -----------------------------------------------------------------------------
module pipe_int_ctrl
  import pipe_int_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_req,
  input  logic       load_use_hazard,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic       fd_enable,
  output logic       fd_flush,
  output logic       de_flush,
  output logic       pc_enable,
  output logic [1:0] pc_sel,
  output logic [1:0] inject_op,
  output logic       int_ack,
  output logic       int_pending
);

  // Counter is loaded with DRAIN_CYC-1 so that DRAIN lasts DRAIN_CYC
  // non-stalled cycles, the last of them at count zero.
  localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYC - 32'd1);

  state_e     state_r, state_s;
  logic [3:0] cnt_r, cnt_s;
  logic       pending_s;
  logic       fd_enable_s, fd_flush_s, de_flush_s, pc_enable_s, int_ack_s;
  logic [1:0] pc_sel_s, inject_op_s;

  int_edge_latch u_edge (
    .clk     (clk),
    .rst     (rst),
    .int_req (int_req),
    .clr     (int_ack_s),
    .pending (pending_s)
  );

  // State and drain counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state, counter and raw output decode.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    fd_enable_s = 1'b0;
    fd_flush_s  = 1'b0;
    de_flush_s  = 1'b0;
    pc_enable_s = 1'b0;
    pc_sel_s    = PC_SEL_SEQ;
    inject_op_s = INJ_NONE;
    int_ack_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_busy) begin
          fd_enable_s = 1'b0;
          pc_enable_s = 1'b0;
        end else if (branch_taken) begin
          pc_sel_s    = PC_SEL_BRANCH;
          pc_enable_s = 1'b1;
          fd_enable_s = 1'b1;
          fd_flush_s  = 1'b1;
          de_flush_s  = 1'b1;
        end else if (load_use_hazard) begin
          de_flush_s  = 1'b1;
        end else begin
          fd_enable_s = 1'b1;
          pc_enable_s = 1'b1;
        end
        // The normal IDLE outputs above still apply on the cycle we leave.
        if (pending_s && !mem_busy) begin
          state_s = DRAIN;
          cnt_s   = CNT_LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        de_flush_s = 1'b1;
        // A late redirect still has to be honoured; it does not disturb
        // the drain count.
        if (branch_taken) begin
          pc_sel_s    = PC_SEL_BRANCH;
          pc_enable_s = 1'b1;
          fd_flush_s  = 1'b1;
        end else begin
          pc_sel_s    = PC_SEL_SEQ;
        end
        if (mem_busy) begin
          cnt_s = cnt_r;
        end else if (cnt_r == 4'd0) begin
          state_s = SAVE_PC;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      SAVE_PC: begin
        inject_op_s = INJ_PUSH_PC;
        if (!mem_busy) begin
          state_s = SAVE_FLAGS;
        end else begin
          state_s = SAVE_PC;
        end
      end
      SAVE_FLAGS: begin
        inject_op_s = INJ_PUSH_FLAGS;
        if (!mem_busy) begin
          state_s = VECTOR;
        end else begin
          state_s = SAVE_FLAGS;
        end
      end
      VECTOR: begin
        pc_sel_s   = PC_SEL_VECTOR;
        fd_flush_s = 1'b1;
        de_flush_s = 1'b1;
        if (!mem_busy) begin
          pc_enable_s = 1'b1;
          int_ack_s   = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s     = VECTOR;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Reset overrides the decoded outputs immediately, independent of the clock.
  always_comb begin
    if (!rst) begin
      fd_enable = 1'b0;
      fd_flush  = 1'b1;
      de_flush  = 1'b1;
      pc_enable = 1'b0;
      pc_sel    = PC_SEL_SEQ;
      inject_op = INJ_NONE;
      int_ack   = 1'b0;
    end else begin
      fd_enable = fd_enable_s;
      fd_flush  = fd_flush_s;
      de_flush  = de_flush_s;
      pc_enable = pc_enable_s;
      pc_sel    = pc_sel_s;
      inject_op = inject_op_s;
      int_ack   = int_ack_s;
    end
  end

  assign int_pending = pending_s;

endmodule
